ls_backtrack_ctrl: RTL

LS_BACKTRACK_CTRL -- requirements
Module: ls_backtrack_ctrl

---
 rtl/ls_backtrack_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ls_backtrack_ctrl.sv
// Armijo backtracking line-search controller: issues trial steps to an external
// cost evaluator, shrinks alpha on rejection and reports the accepted step.
module ls_backtrack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_ITER   = 8
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 start,
  input  logic signed [DATA_WIDTH-1:0]         phi0,
  input  logic signed [DATA_WIDTH-1:0]         dphi0,
  input  logic signed [DATA_WIDTH-1:0]         rho,
  input  logic signed [DATA_WIDTH-1:0]         tau,
  input  logic signed [DATA_WIDTH-1:0]         alpha_init,
  output logic                                 eval_req_valid,
  input  logic                                 eval_req_ready,
  output logic signed [DATA_WIDTH-1:0]         eval_alpha,
  input  logic                                 eval_rsp_valid,
  input  logic signed [DATA_WIDTH-1:0]         eval_rsp_phi,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 accepted,
  output logic signed [DATA_WIDTH-1:0]         alpha_out,
  output logic [$clog2(MAX_ITER+1)-1:0]        iter_count
);

  localparam int IW = $clog2(MAX_ITER+1);
  localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER);
  localparam logic [IW-1:0] ITER_ONE  = IW'(1);

  typedef enum logic [2:0] {IDLE, PREP, REQ, WAIT, CMP, SHRINK, DONE} state_t;

  // Fixed-point multiply: full-width product, arithmetic shift, truncate.
  function automatic logic signed [DATA_WIDTH-1:0] fx_mul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    p = p >>> FRAC_BITS;
    return p[DATA_WIDTH-1:0];
  endfunction

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] phi0_r, dphi0_r, rho_r, tau_r;
  logic signed [DATA_WIDTH-1:0] alpha, thr_k, phi_a;

  logic signed [DATA_WIDTH-1:0] alpha_next, bound;
  logic signed [DATA_WIDTH:0]   diff, bound_x;
  logic                         accept, shrink_stop;

  // Armijo test evaluated one bit wider so phi_a - phi0 cannot wrap.
  always_comb begin
    alpha_next  = fx_mul(alpha, tau_r);
    bound       = fx_mul(thr_k, alpha);
    diff        = {phi_a[DATA_WIDTH-1], phi_a} - {phi0_r[DATA_WIDTH-1], phi0_r};
    bound_x     = {bound[DATA_WIDTH-1], bound};
    accept      = (diff <= bound_x);
    shrink_stop = (iter_count == ITER_LAST) || alpha_next[DATA_WIDTH-1] ||
                  (alpha_next == '0);
  end

  assign eval_alpha = alpha;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      eval_req_valid <= 1'b0;
      accepted       <= 1'b0;
      alpha          <= '0;
      alpha_out      <= '0;
      iter_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            phi0_r     <= phi0;
            dphi0_r    <= dphi0;
            rho_r      <= rho;
            tau_r      <= tau;
            alpha      <= alpha_init;
            iter_count <= '0;
            busy       <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          thr_k          <= fx_mul(rho_r, dphi0_r);
          eval_req_valid <= 1'b1;
          state          <= REQ;
        end
        REQ: begin
          if (eval_req_ready) begin
            eval_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (eval_rsp_valid) begin
            phi_a      <= eval_rsp_phi;
            iter_count <= iter_count + ITER_ONE;
            state      <= CMP;
          end
        end
        CMP: begin
          if (accept) begin
            accepted  <= 1'b1;
            alpha_out <= alpha;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= SHRINK;
          end
        end
        SHRINK: begin
          alpha <= alpha_next;
          // A failed search reports the last step actually evaluated.
          if (shrink_stop) begin
            accepted  <= 1'b0;
            alpha_out <= alpha;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            eval_req_valid <= 1'b1;
            state          <= REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
